// File: rtl/mult_pkg.sv
// Shared widths and operand type for the sequential shift-and-add multiplier.
// The product register and the left shifter share OUT_W.
package mult_pkg;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 14;
  localparam int PROD_W = OUT_W;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [OUT_W-1:0] product_t;

endpackage : mult_pkg

// File: rtl/shift_left.sv
// Multiplier shifter: zero-extends an IN_W operand into OUT_W bits on load,
// then moves it up one bit per shift_en, discarding the bit leaving the MSB.
module shift_left #(
  parameter int IN_W  = mult_pkg::IN_W,
  parameter int OUT_W = mult_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q
);

  logic [OUT_W-1:0] q_r;

  // Priority: rst > load > shift_en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= {{(OUT_W-IN_W){1'b0}}, d};
    end else if (shift_en) begin
      q_r <= {q_r[OUT_W-2:0], 1'b0};
    end
  end

  assign q = q_r;

endmodule : shift_left

// File: rtl/shift_right.sv
// Multiplicand shifter: loads an IN_W operand, then shifts it logically down
// one bit per shift_en so bit 0 selects the current partial product.
module shift_right #(
  parameter int IN_W = mult_pkg::IN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift_en,
  input  logic [IN_W-1:0] d,
  output logic [IN_W-1:0] q
);

  logic [IN_W-1:0] q_r;

  // Unsigned magnitudes: zero fills from the top, never sign-extended.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else if (shift_en) begin
      q_r <= {1'b0, q_r[IN_W-1:1]};
    end
  end

  assign q = q_r;

endmodule : shift_right

// File: rtl/operand_shifters.sv
// Operand-alignment stage: the two shifters step in lockstep from shared
// load/shift_en, so after k shifts left = multiplier<<k and right = multiplicand>>k.
module operand_shifters #(
  parameter int IN_W  = mult_pkg::IN_W,
  parameter int OUT_W = mult_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  multiplier,
  input  logic [IN_W-1:0]  multiplicand,
  output logic [OUT_W-1:0] shifted_multiplier,
  output logic [IN_W-1:0]  shifted_multiplicand
);

  import mult_pkg::*;

  // Control contract: load and shift_en are single-cycle strobes with no
  // handshake back; each takes effect on the edge that samples it.
  shift_left #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_shift_left (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .d        (multiplier),
    .q        (shifted_multiplier)
  );

  shift_right #(
    .IN_W (IN_W)
  ) u_shift_right (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .d        (multiplicand),
    .q        (shifted_multiplicand)
  );

endmodule : operand_shifters

// File: tb/tb_operand_shifters.sv
// Bench for operand_shifters: directed vector table, a restart sequence,
// then randomized traffic against an arithmetic model.
module tb_operand_shifters;

  localparam int IN_W  = 8;
  localparam int OUT_W = 14;
  localparam int N_VEC = 23;
  localparam int N_RAND = 10000;

  typedef struct {
    logic             rst;
    logic             load;
    logic             shift_en;
    logic [IN_W-1:0]  mplier;
    logic [IN_W-1:0]  mcand;
    logic [OUT_W-1:0] exp_left;
    logic [IN_W-1:0]  exp_right;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic             shift_en = 1'b0;
  logic [IN_W-1:0]  multiplier = '0;
  logic [IN_W-1:0]  multiplicand = '0;
  logic [OUT_W-1:0] shifted_multiplier;
  logic [IN_W-1:0]  shifted_multiplicand;

  int n_vec = 0;
  int n_err = 0;

  logic [OUT_W+IN_W-1:0] exp_q[$];

  vec_t vecs[N_VEC];

  // Model state: the loaded operands and how many shifts happened since.
  int unsigned m_mplier = 0;
  int unsigned m_mcand  = 0;
  int unsigned m_k      = 0;

  always #5 clk = ~clk;

  operand_shifters #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .load                 (load),
    .shift_en             (shift_en),
    .multiplier           (multiplier),
    .multiplicand         (multiplicand),
    .shifted_multiplier   (shifted_multiplier),
    .shifted_multiplicand (shifted_multiplicand)
  );

  task automatic drive(input logic r, input logic l, input logic s,
                       input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    rst = r;
    load = l;
    shift_en = s;
    multiplier = a;
    multiplicand = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [OUT_W-1:0] exp_l,
                       input logic [IN_W-1:0] exp_r);
    n_vec++;
    if (shifted_multiplier !== exp_l || shifted_multiplicand !== exp_r) begin
      n_err++;
      $display("FAIL %s: got left=%h right=%h, expected left=%h right=%h",
               name, shifted_multiplier, shifted_multiplicand, exp_l, exp_r);
    end
  endtask

  function automatic logic [OUT_W+IN_W-1:0] model_out();
    longint unsigned left;
    int unsigned right;
    left  = (m_k >= OUT_W) ? 0 : ((longint'(m_mplier) << m_k) % (64'd1 << OUT_W));
    right = (m_k >= IN_W) ? 0 : (m_mcand >> m_k);
    return {left[OUT_W-1:0], right[IN_W-1:0]};
  endfunction

  initial begin
    vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 14'h0000, 8'h00};
    vecs[1]  = '{0, 1, 0, 8'hFF, 8'hA5, 14'h00FF, 8'hA5};
    vecs[2]  = '{1, 1, 0, 8'hFF, 8'hA5, 14'h0000, 8'h00};
    vecs[3]  = '{0, 1, 0, 8'hFF, 8'hA5, 14'h00FF, 8'hA5};
    vecs[4]  = '{0, 0, 1, 8'h00, 8'h00, 14'h01FE, 8'h52};
    vecs[5]  = '{0, 0, 1, 8'h00, 8'h00, 14'h03FC, 8'h29};
    vecs[6]  = '{0, 0, 1, 8'h00, 8'h00, 14'h07F8, 8'h14};
    vecs[7]  = '{0, 0, 1, 8'h00, 8'h00, 14'h0FF0, 8'h0A};
    vecs[8]  = '{0, 0, 1, 8'h00, 8'h00, 14'h1FE0, 8'h05};
    vecs[9]  = '{0, 0, 1, 8'h00, 8'h00, 14'h3FC0, 8'h02};
    vecs[10] = '{0, 0, 1, 8'h00, 8'h00, 14'h3F80, 8'h01};
    vecs[11] = '{0, 0, 1, 8'h00, 8'h00, 14'h3F00, 8'h00};
    vecs[12] = '{0, 0, 1, 8'h00, 8'h00, 14'h3E00, 8'h00};
    vecs[13] = '{0, 1, 1, 8'h03, 8'h80, 14'h0003, 8'h80};
    vecs[14] = '{0, 1, 0, 8'h12, 8'h34, 14'h0012, 8'h34};
    vecs[15] = '{0, 0, 0, 8'h00, 8'h00, 14'h0012, 8'h34};
    vecs[16] = '{0, 0, 0, 8'hFF, 8'hFF, 14'h0012, 8'h34};
    vecs[17] = '{0, 0, 0, 8'h00, 8'h00, 14'h0012, 8'h34};
    vecs[18] = '{0, 0, 0, 8'h55, 8'hAA, 14'h0012, 8'h34};
    vecs[19] = '{0, 0, 0, 8'h00, 8'h00, 14'h0012, 8'h34};
    vecs[20] = '{0, 0, 1, 8'h00, 8'h00, 14'h0024, 8'h1A};
    vecs[21] = '{1, 0, 1, 8'h00, 8'h00, 14'h0000, 8'h00};
    vecs[22] = '{0, 0, 1, 8'h00, 8'h00, 14'h0000, 8'h00};

    // The 7th shift of 0xFF: 0xFF<<7 = 0x7F80, which is 0x3F80 in 14 bits.
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].shift_en, vecs[i].mplier, vecs[i].mcand);
      check($sformatf("vec%0d", i), vecs[i].exp_left, vecs[i].exp_right);
    end

    // Restart mid-operation: load, two shifts, reload, one shift.
    drive(0, 1, 0, 8'hC3, 8'hF0);
    drive(0, 0, 1, 8'h00, 8'h00);
    drive(0, 0, 1, 8'h00, 8'h00);
    check("restart_pre", 14'h030C, 8'h3C);
    drive(0, 1, 0, 8'h81, 8'h0F);
    check("restart_load", 14'h0081, 8'h0F);
    drive(0, 0, 1, 8'h00, 8'h00);
    check("restart_shift", 14'h0102, 8'h07);

    // Random regression against the arithmetic model.
    drive(1, 0, 0, 8'h00, 8'h00);
    m_mplier = 0; m_mcand = 0; m_k = 0;
    for (int i = 0; i < N_RAND; i++) begin
      logic r, l, s;
      logic [IN_W-1:0] a, b;
      logic [OUT_W+IN_W-1:0] e;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 1) == 1);
      a = IN_W'($urandom);
      b = IN_W'($urandom);
      if (r) begin
        m_mplier = 0; m_mcand = 0; m_k = 0;
      end else if (l) begin
        m_mplier = a; m_mcand = b; m_k = 0;
      end else if (s && m_k < 32) begin
        m_k++;
      end
      exp_q.push_back(model_out());
      drive(r, l, s, a, b);
      e = exp_q.pop_front();
      check("random", e[OUT_W+IN_W-1:IN_W], e[IN_W-1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_operand_shifters
